// File: rtl/fp_convert_arbiter_if.sv
// Requester, converter and response signals of the shared float-to-int arbiter.
// The slave side is the arbiter; the master side is the requesters, converter and consumer.
interface fp_convert_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_float;
    logic [NUM_REQ-1:0]    req_ready;
    logic [31:0]           cvt_float;
    logic [31:0]           cvt_int;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_int;
    logic [ID_W-1:0]       resp_id;
    logic                  busy;

    modport slave (
        input  req_valid, req_float, cvt_int, resp_ready,
        output req_ready, cvt_float, resp_valid, resp_int, resp_id, busy
    );

    modport master (
        output req_valid, req_float, cvt_int, resp_ready,
        input  req_ready, cvt_float, resp_valid, resp_int, resp_id, busy
    );
endinterface

// File: rtl/fp_convert_arbiter.sv
// Round-robin, credit-admitted sharing of one fixed-latency float-to-int converter.
// Results are tagged with the issuing requester and returned in issue order.
module fp_convert_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int CVT_LATENCY = 1,
    parameter int RESP_DEPTH  = 4,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                clock,
    input  logic                reset,
    fp_convert_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int AW    = $clog2(RESP_DEPTH);
    localparam logic [CNT_W:0]  L_DEPTH = (CNT_W + 1)'(RESP_DEPTH);
    localparam logic [ID_W:0]   L_NUM   = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] L_LAST  = ID_W'(NUM_REQ - 1);
    localparam logic [AW-1:0]   L_PEND  = AW'(RESP_DEPTH - 1);

    logic [ID_W-1:0]        r_rr_ptr;
    logic [CVT_LATENCY-1:0] r_tag_vld;
    logic [ID_W-1:0]        r_tag_id [CVT_LATENCY];
    logic [31:0]            r_fifo_int [RESP_DEPTH];
    logic [ID_W-1:0]        r_fifo_id [RESP_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CNT_W-1:0]       r_fifo_count;
    logic [CNT_W-1:0]       r_inflight_count;

    logic                   w_can_issue;
    logic                   w_grant_vld;
    logic [ID_W-1:0]        w_grant_idx;
    logic [CNT_W:0]         w_credit_used;
    logic                   w_push;
    logic                   w_pop;

    // Credits come from registered counts only, so a pop frees its slot one cycle later.
    assign w_credit_used = {1'b0, r_fifo_count} + {1'b0, r_inflight_count};
    assign w_can_issue   = w_credit_used < L_DEPTH;

    always_comb begin
        logic [ID_W:0] w_sum;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
            if (w_sum >= L_NUM) w_sum = w_sum - L_NUM;
            if (!w_grant_vld && bus.req_valid[w_sum[ID_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_sum[ID_W-1:0];
            end
        end
        if (!w_can_issue || reset) w_grant_vld = 1'b0;
    end

    always_comb begin
        bus.req_ready = '0;
        bus.cvt_float = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_vld && (w_grant_idx == ID_W'(i))) begin
                bus.req_ready[i] = 1'b1;
                bus.cvt_float    = bus.req_float[i*32 +: 32];
            end
        end
    end

    assign w_push         = r_tag_vld[CVT_LATENCY-1];
    assign w_pop          = bus.resp_valid & bus.resp_ready;
    assign bus.resp_valid = (r_fifo_count != '0);
    assign bus.busy       = (r_fifo_count != '0) || (r_inflight_count != '0);
    assign bus.resp_int   = r_fifo_int[r_rd_ptr];
    assign bus.resp_id    = r_fifo_id[r_rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr         <= '0;
            r_tag_vld        <= '0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_fifo_count     <= '0;
            r_inflight_count <= '0;
            for (int s = 0; s < CVT_LATENCY; s++) r_tag_id[s] <= '0;
        end else begin
            if (w_grant_vld) r_rr_ptr <= (w_grant_idx == L_LAST) ? '0 : w_grant_idx + 1'b1;
            r_tag_vld[0] <= w_grant_vld;
            r_tag_id[0]  <= w_grant_idx;
            for (int s = 1; s < CVT_LATENCY; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
            if (w_push) r_wr_ptr <= (r_wr_ptr == L_PEND) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == L_PEND) ? '0 : r_rd_ptr + 1'b1;
            r_fifo_count     <= r_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_inflight_count <= r_inflight_count + CNT_W'(w_grant_vld) - CNT_W'(w_push);
        end
    end

    // Storage needs no reset: entries are only read while the count marks them live.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_int[r_wr_ptr] <= bus.cvt_int;
            r_fifo_id[r_wr_ptr]  <= r_tag_id[CVT_LATENCY-1];
        end
    end
endmodule

// File: tb/tb_fp_convert_arbiter.sv
// Self-checking bench for fp_convert_arbiter: directed vectors, corner sequences and
// randomized traffic compared against a queue-based model of outstanding conversions.
module tb_fp_convert_arbiter;
    localparam int N     = 4;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;
    localparam int IDW   = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   ntests = 0;
    int   nfail  = 0;

    fp_convert_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus();

    fp_convert_arbiter #(
        .NUM_REQ(N), .CVT_LATENCY(LAT), .RESP_DEPTH(DEPTH), .ID_W(IDW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Shared converter: one registered stage, truncation toward zero, saturating.
    function automatic logic [31:0] f2i(logic [31:0] f);
        int          e;
        logic [55:0] m;
        logic [31:0] mag;
        e = int'({24'b0, f[30:23]}) - 127;
        if (e < 0) return 32'h0;
        if (e > 30) return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        m = {32'b0, 1'b1, f[22:0]};
        if (e >= 23) m = m << (e - 23);
        else         m = m >> (23 - e);
        mag = m[31:0];
        return f[31] ? -mag : mag;
    endfunction

    always @(posedge clock) bus.cvt_int <= f2i(bus.cvt_float);

    typedef struct {
        int          req;
        logic [31:0] fbits;
        logic [31:0] ival;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] ival;
        int          avail;
    } exp_t;

    vec_t vecs[10];
    exp_t q[$];
    int   obs_g[$];
    int   m_ptr = 0;
    int   gcount[N];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] lookup(logic [31:0] f);
        foreach (vecs[i]) if (vecs[i].fbits == f) return vecs[i].ival;
        return 32'hDEAD_BEEF;
    endfunction

    // Compare this cycle's outputs against the model, then advance the model to the next edge.
    task automatic check_cycle();
        logic [N-1:0] exp_rdy;
        logic [31:0]  exp_cvt;
        logic         exp_rv;
        int           g;
        int           idx;
        exp_rdy = '0;
        exp_cvt = '0;
        g       = -1;
        if (!reset && q.size() < DEPTH) begin
            for (int j = 0; j < N; j++) begin
                idx = (m_ptr + j) % N;
                if (g < 0 && bus.req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            exp_cvt    = bus.req_float[g*32 +: 32];
        end
        exp_rv = (q.size() > 0) && (q[0].avail <= cyc);
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("cvt_float", bus.cvt_float, exp_cvt);
        chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
        chk("busy", 32'(bus.busy), 32'(q.size() > 0));
        for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i] && bus.req_valid[i]) begin
                gcount[i]++;
                obs_g.push_back(i);
            end
        end
        if (exp_rv && bus.resp_ready) begin
            chk("resp_int", bus.resp_int, q[0].ival);
            chk("resp_id", 32'(bus.resp_id), 32'(q[0].id));
            void'(q.pop_front());
        end
        if (g >= 0) begin
            q.push_back('{g, lookup(exp_cvt), cyc + LAT + 1});
            m_ptr = (g + 1) % N;
        end
    endtask

    task automatic step(int n = 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            check_cycle();
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_obs();
        obs_g.delete();
        for (int i = 0; i < N; i++) gcount[i] = 0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        q.delete();
        m_ptr = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_float(int i, logic [31:0] f);
        bus.req_float[i*32 +: 32] = f;
    endtask

    initial begin
        int acc;
        vecs[0] = '{0, 32'h3F80_0000, 32'd1};
        vecs[1] = '{1, 32'h42C8_0000, 32'd100};
        vecs[2] = '{2, 32'hC020_0000, 32'hFFFF_FFFE};
        vecs[3] = '{3, 32'h0000_0000, 32'd0};
        vecs[4] = '{1, 32'h3F00_0000, 32'd0};
        vecs[5] = '{3, 32'hBF80_0000, 32'hFFFF_FFFF};
        vecs[6] = '{2, 32'h4B00_0001, 32'h0080_0001};
        vecs[7] = '{0, 32'h447A_0000, 32'd1000};
        vecs[8] = '{1, 32'hC2F7_0000, 32'hFFFF_FF85};
        vecs[9] = '{2, 32'h4049_0FDB, 32'd3};

        bus.req_valid  = 4'hF;
        bus.req_float  = '0;
        bus.resp_ready = 1'b1;
        bus.cvt_int    = '0;
        #1;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_cvt_float", bus.cvt_float, 32'd0);
        bus.req_valid = '0;
        @(posedge clock);
        do_reset();

        // Single requests: accept in cycle t, response at t+2, busy clears after the pop.
        foreach (vecs[v]) begin
            set_float(vecs[v].req, vecs[v].fbits);
            bus.req_valid = N'(1) << vecs[v].req;
            step();
            bus.req_valid = '0;
            step();
            chk("lat_valid", 32'(bus.resp_valid), 32'd1);
            chk("lat_int", bus.resp_int, vecs[v].ival);
            chk("lat_id", 32'(bus.resp_id), 32'(vecs[v].req));
            step(3);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end

        // All four streaming with the consumer always ready.
        do_reset();
        clear_obs();
        set_float(0, 32'h3F80_0000);
        set_float(1, 32'h42C8_0000);
        set_float(2, 32'hC020_0000);
        set_float(3, 32'h0000_0000);
        bus.req_valid = 4'hF;
        step(16);
        chk("stream_grants", 32'(obs_g.size()), 32'd16);
        for (int k = 0; k < obs_g.size() && k < 8; k++) chk("stream_order", 32'(obs_g[k]), 32'(k % N));
        bus.req_valid = '0;
        step(4);

        // Fairness between two requesters.
        do_reset();
        clear_obs();
        bus.req_valid = 4'b1010;
        step(12);
        chk("fair_r0", 32'(gcount[0]), 32'd0);
        chk("fair_r2", 32'(gcount[2]), 32'd0);
        chk("fair_r1", 32'(gcount[1]), 32'd6);
        chk("fair_r3", 32'(gcount[3]), 32'd6);
        for (int k = 0; k < obs_g.size(); k++) chk("fair_seq", 32'(obs_g[k]), (k % 2) ? 32'd3 : 32'd1);
        bus.req_valid = '0;
        step(4);

        // Backpressure: exactly DEPTH accepts, then drain and resume.
        do_reset();
        clear_obs();
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'hF;
        step(8);
        acc = 0;
        for (int i = 0; i < N; i++) acc += gcount[i];
        chk("bp_accepts", 32'(acc), 32'(DEPTH));
        chk("bp_ready_zero", 32'(bus.req_ready), 32'd0);
        bus.resp_ready = 1'b1;
        step(10);
        bus.req_valid = '0;
        step(6);

        // Full FIFO with toggling consumer: simultaneous push and pop at high occupancy.
        do_reset();
        bus.req_valid = 4'hF;
        for (int k = 0; k < 40; k++) begin
            bus.resp_ready = k[0];
            step();
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        step(8);

        // Asynchronous reset with one conversion in flight and three buffered.
        do_reset();
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'hF;
        step(4);
        chk("pre_rst_valid", 32'(bus.resp_valid), 32'd1);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        q.delete();
        m_ptr          = 0;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #3;
        reset = 1'b0;
        step(5);
        clear_obs();
        bus.req_valid = 4'b1100;
        step();
        chk("post_rst_first", (obs_g.size() > 0) ? 32'(obs_g[0]) : 32'hFFFF_FFFF, 32'd2);
        bus.req_valid = '0;
        step(4);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] || $urandom_range(0, 3) == 0)
                    set_float(i, vecs[$urandom_range(0, 9)].fbits);
            end
            bus.req_valid  = N'($urandom_range(0, 15));
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        step(10);
        chk("final_idle", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/fp_convert_arbiter.md
# fp_convert_arbiter

Round-robin arbiter that shares one float-to-int converter among `NUM_REQ` requesters, such as lanes or issue slots of a miniGPU core. The shared converter is a fixed-latency unit with no handshake and no reset. This block decides which requester issues each cycle and tags every conversion with its source ID. It buffers results in an in-order response FIFO and uses credit-based admission, so no result is ever dropped under response backpressure.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `CVT_LATENCY`, default 1: cycles from the converter sampling its input to its result being valid; matches the one registered stage of the converter.
- `RESP_DEPTH`, default 4: response FIFO entries, ≥ `CVT_LATENCY`+1.
- `ID_W`, default `$clog2(NUM_REQ)`: width of `resp_id`.

Ports:
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, `NUM_REQ`: per-requester request valid.
- `req_float`, in, `NUM_REQ*32`: packed IEEE-754 single operands; requester i occupies bits [32i+31:32i].
- `req_ready`, out, `NUM_REQ`: one-hot-or-zero grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- `cvt_float`, out, 32: operand to the shared converter.
- `cvt_int`, in, 32: converter result.
- `resp_valid`, out, 1: FIFO head valid.
- `resp_ready`, in, 1: consumer accepts the head.
- `resp_int`, out, 32: converted integer at the FIFO head.
- `resp_id`, out, `ID_W`: index of the requester that issued the head entry.
- `busy`, out, 1: high while any conversion is in flight or the FIFO is non-empty.

## Operation
- Credit check: `can_issue = (fifo_count + inflight_count) < RESP_DEPTH`.
  - The check uses registered counts only.
  - A pop in the same cycle does not free a credit until the next cycle.
- Arbitration:
  - The round-robin pointer `rr_ptr` holds the highest-priority index.
  - The grant goes to the first i with `req_valid[i]=1`, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
  - The grant is gated by `can_issue`.
  - `req_ready` is combinational from `req_valid`, `rr_ptr` and the counts.
  - On a grant to i, `rr_ptr <= (i+1) mod NUM_REQ`. With no grant, `rr_ptr` is unchanged.
- Issue:
  - `cvt_float = req_float[grant]` on a grant cycle, otherwise 32'h0.
  - A tag shift register of `CVT_LATENCY` stages holds {valid, id}; an issue enters {1, grant index}.
- Capture: when the last tag stage is valid, `{tag.id, cvt_int}` is pushed into the FIFO on that cycle's edge.
- Response: FIFO head drives `resp_int`/`resp_id`. A pop occurs on `resp_valid & resp_ready`. Order is strictly issue order.
- Simultaneous push and pop are legal at any occupancy, including full, because the credit check guarantees a free slot for every in-flight result.
- Requesters must hold `req_float[i]` stable while `req_valid[i]=1` and not yet granted; the block does not check this.
- The converter has no reset. Its output is ignored unless a valid tag is in the last stage.

## Timing
- Reset values, asserted asynchronously:
  - `rr_ptr`=0, tags all invalid, `fifo_count`=0, `inflight_count`=0.
  - Resulting outputs: `resp_valid`=0, `busy`=0, `req_ready`=0 while reset is high, `cvt_float`=0.
- Reset mid-operation discards all in-flight and buffered results. No stale response appears after release.
- Latency: an accept in cycle t gives `resp_valid`=1 in cycle t+`CVT_LATENCY`+1 when the FIFO was empty. This is cycle t+2 with the defaults.
- Throughput: one issue per cycle while credits last.
  - With `resp_ready` tied high and `RESP_DEPTH` ≥ `CVT_LATENCY`+2, sustained rate is 1/cycle.
  - At the minimum depth, rate is bounded by credit turnaround.
- `busy` is registered-state derived; it falls the cycle after the last pop.

## Test plan
- Single request: `req_valid[0]`=1, `req_float[0]`=32'h3F800000 (1.0) in cycle 0. Expected: `req_ready[0]`=1 in cycle 0; cycle 2 shows `resp_valid`=1, `resp_int`=1, `resp_id`=0. Release req0; `busy` falls after the pop.
- All four valid continuously with `resp_ready`=1, operands 1.0, 100.0 (32'h42C80000), -2.5 (32'hC0200000), 0.0. Expected: grants 0,1,2,3,0,… one per cycle; responses 1, 100, -2, 0 with IDs 0,1,2,3 in order.
- Fairness: only req1 and req3 valid continuously. Expected: grants alternate 1,3,1,3; req0 and req2 never granted.
- Backpressure: `resp_ready`=0, all requesters valid. Expected: exactly 4 accepts in total, then `req_ready` all 0. Raise `resp_ready`: 4 responses drain in order and issue resumes the cycle after the first pop frees a credit.
- Full FIFO with simultaneous push and pop: keep the FIFO at 4 entries with `resp_ready` toggling. Expected: no lost or duplicated responses; `fifo_count` never exceeds 4.
- Reset mid-stream: with 1 conversion in flight and 3 buffered, assert `reset` asynchronously mid-cycle. Expected: `resp_valid` and `busy` drop immediately; after release there are no responses until a new request, and the first grant goes to the lowest valid index from 0.
